// File: rtl/wb_host_initiator.sv
// Single-outstanding Wishbone-style bus initiator: takes one host command, runs one strobe
// on the bus until ack or timeout, then holds the response until the host takes it.
//
// state | meaning
// IDLE  | cmd_ready_o high, waiting for a host command
// BUS   | wb_stb_o high, waiting for wb_ack_i or timeout
// RESP  | rsp_valid_o high, holding response until rsp_ready_i
module wb_host_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk40MHz_i,
    input  logic        rst_n_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_adr_i,
    input  logic        cmd_wen_i,
    input  logic [7:0]  cmd_dat_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_dat_o,
    output logic        rsp_err_o,

    output logic [15:0] wb_adr_o,
    output logic        wb_wen_o,
    output logic        wb_stb_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_val_i,

    output logic [7:0]  txn_cnt_o,
    output logic [7:0]  err_cnt_o
);

    // One-hot so each handshake output is a flop bit; reset clears wb_stb_o without a clock.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUS  = 3'b010,
        RESP = 3'b100
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    assign cmd_ready_o = state[0];
    assign wb_stb_o    = state[1];
    assign rsp_valid_o = state[2];

    // Slave-select is informational only; completion is decided by wb_ack_i alone.
    logic unused_val;
    assign unused_val = wb_val_i;

    always_ff @(posedge clk40MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            wb_adr_o  <= '0;
            wb_wen_o  <= 1'b0;
            wb_dat_o  <= '0;
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b0;
            txn_cnt_o <= '0;
            err_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wb_adr_o <= cmd_adr_i;
                        wb_wen_o <= cmd_wen_i;
                        wb_dat_o <= cmd_dat_i;
                        wait_cnt <= '0;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        rsp_dat_o <= wb_wen_o ? 8'h00 : wb_dat_i;
                        rsp_err_o <= 1'b0;
                        txn_cnt_o <= txn_cnt_o + 8'd1;
                        state     <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_dat_o <= 8'h00;
                        rsp_err_o <= 1'b1;
                        txn_cnt_o <= txn_cnt_o + 8'd1;
                        if (err_cnt_o != 8'hFF) begin
                            err_cnt_o <= err_cnt_o + 8'd1;
                        end
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_initiator.sv
// Directed bench for wb_host_initiator: vector table of single transactions against a
// small memory slave, plus hand-written backpressure, reset-abort and counter-limit sequences.
module tb_wb_host_initiator;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int TO = 8;

    logic        clk40MHz_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [15:0] cmd_adr_i = '0;
    logic        cmd_wen_i = 1'b0;
    logic [7:0]  cmd_dat_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [7:0]  rsp_dat_o;
    logic        rsp_err_o;
    logic [15:0] wb_adr_o;
    logic        wb_wen_o;
    logic        wb_stb_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i;
    logic        wb_ack_i;
    logic        wb_val_i;
    logic [7:0]  txn_cnt_o;
    logic [7:0]  err_cnt_o;

    wb_host_initiator #(.TIMEOUT(TO)) dut (
        .clk40MHz_i  (clk40MHz_i),
        .rst_n_i     (rst_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_wen_i   (cmd_wen_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wb_adr_o    (wb_adr_o),
        .wb_wen_o    (wb_wen_o),
        .wb_stb_o    (wb_stb_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_val_i    (wb_val_i),
        .txn_cnt_o   (txn_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #12.5 clk40MHz_i = ~clk40MHz_i;

    // Slave: 16 bytes mapped at 0x0000-0x000F, ack after ack_delay strobe cycles.
    logic [7:0] mem [0:15];
    int         ack_delay = 0;
    logic       ack_force = 1'b0;
    int         stb_age = 0;

    assign wb_val_i = (wb_adr_o[15:4] == 12'h000);
    assign wb_ack_i = (wb_stb_o & wb_val_i & (stb_age >= ack_delay)) | ack_force;
    assign wb_dat_i = mem[wb_adr_o[3:0]];

    always @(posedge clk40MHz_i) begin
        stb_age <= wb_stb_o ? stb_age + 1 : 0;
        if (wb_stb_o && wb_ack_i && wb_wen_o) mem[wb_adr_o[3:0]] <= wb_dat_o;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input logic wen, input logic [15:0] adr, input logic [7:0] dat,
                          output logic [7:0] r_dat, output logic r_err,
                          output int stb_cyc, output int lat, output logic hold_ok);
        int guard = 0;
        @(negedge clk40MHz_i);
        while (!cmd_ready_o && guard < 50) begin
            @(negedge clk40MHz_i);
            guard++;
        end
        chk("cmd_ready_seen", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_wen_i   = wen;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        @(negedge clk40MHz_i);
        cmd_valid_i = 1'b0;
        lat = 1;
        stb_cyc = 0;
        hold_ok = 1'b1;
        while (!rsp_valid_o && lat < 400) begin
            if (wb_stb_o) begin
                stb_cyc++;
                if (wb_adr_o !== adr || wb_wen_o !== wen || wb_dat_o !== dat) hold_ok = 1'b0;
            end
            @(negedge clk40MHz_i);
            lat++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid_o), 32'd1);
        r_dat = rsp_dat_o;
        r_err = rsp_err_o;
        rsp_ready_i = 1'b1;
        @(negedge clk40MHz_i);
        rsp_ready_i = 1'b0;
    endtask

    typedef struct {
        logic        wen;
        logic [15:0] adr;
        logic [7:0]  dat;
        logic [7:0]  e_dat;
        logic        e_err;
        int          e_stb;
        int          e_lat;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] r_dat;
    logic       r_err;
    int         stb_cyc;
    int         lat;
    logic       hold_ok;
    int         exp_txn = 0;
    int         exp_err = 0;

    initial begin
        #(25.0 * 20000);
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        vecs[0] = '{1'b1, 16'h0000, 8'h5A, 8'h00, 1'b0, 1,  2};
        vecs[1] = '{1'b0, 16'h0000, 8'h00, 8'h5A, 1'b0, 1,  2};
        vecs[2] = '{1'b1, 16'h0003, 8'hC3, 8'h00, 1'b0, 1,  2};
        vecs[3] = '{1'b0, 16'h0003, 8'hFF, 8'hC3, 1'b0, 1,  2};
        vecs[4] = '{1'b0, 16'hFFE0, 8'h00, 8'h00, 1'b1, TO, TO + 1};
        vecs[5] = '{1'b0, 16'h0001, 8'h00, 8'h00, 1'b0, 1,  2};
        vecs[6] = '{1'b1, 16'h0010, 8'hA5, 8'h00, 1'b1, TO, TO + 1};
        vecs[7] = '{1'b0, 16'h0000, 8'h00, 8'h5A, 1'b0, 1,  2};

        // Reset values
        repeat (3) @(negedge clk40MHz_i);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_wb_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_rsp_dat", 32'(rsp_dat_o), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_txn_cnt", 32'(txn_cnt_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        rst_n_i = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].wen, vecs[i].adr, vecs[i].dat, r_dat, r_err, stb_cyc, lat, hold_ok);
            exp_txn++;
            if (vecs[i].e_err) exp_err++;
            chk($sformatf("v%0d_rsp_dat", i), 32'(r_dat), 32'(vecs[i].e_dat));
            chk($sformatf("v%0d_rsp_err", i), 32'(r_err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_stb_cycles", i), 32'(stb_cyc), 32'(vecs[i].e_stb));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].e_lat));
            chk($sformatf("v%0d_bus_hold", i), 32'(hold_ok), 32'd1);
            chk($sformatf("v%0d_adr_kept", i), 32'(wb_adr_o), 32'(vecs[i].adr));
            chk($sformatf("v%0d_txn_cnt", i), 32'(txn_cnt_o), 32'(exp_txn));
            chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt_o), 32'(exp_err));
            if (vecs[i].wen && vecs[i].adr[15:4] == 12'h000)
                chk($sformatf("v%0d_slave_reg", i), 32'(mem[vecs[i].adr[3:0]]), 32'(vecs[i].dat));
        end
        chk("unmapped_write_no_alias", 32'(mem[0]), 32'h5A);

        // Stray ack while idle
        @(negedge clk40MHz_i);
        ack_force = 1'b1;
        repeat (3) @(negedge clk40MHz_i);
        chk("idle_ack_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("idle_ack_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("idle_ack_txn_cnt", 32'(txn_cnt_o), 32'(exp_txn));
        ack_force = 1'b0;

        // Response backpressure with a command held valid
        cmd_valid_i = 1'b1; cmd_wen_i = 1'b0; cmd_adr_i = 16'h0000; cmd_dat_i = 8'h00;
        @(negedge clk40MHz_i);
        chk("bp_stb_issue", 32'(wb_stb_o), 32'd1);
        @(negedge clk40MHz_i);
        chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
        ack_force = 1'b1;
        hold_ok = 1'b1;
        repeat (10) begin
            @(negedge clk40MHz_i);
            if (!rsp_valid_o || rsp_dat_o !== 8'h5A || rsp_err_o || cmd_ready_o || wb_stb_o)
                hold_ok = 1'b0;
        end
        chk("bp_rsp_hold", 32'(hold_ok), 32'd1);
        ack_force = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk40MHz_i);
        rsp_ready_i = 1'b0;
        chk("bp_idle_stb", 32'(wb_stb_o), 32'd0);
        chk("bp_idle_ready", 32'(cmd_ready_o), 32'd1);
        @(negedge clk40MHz_i);
        chk("bp_next_stb", 32'(wb_stb_o), 32'd1);
        cmd_valid_i = 1'b0;
        @(negedge clk40MHz_i);
        chk("bp_next_rsp_dat", 32'(rsp_dat_o), 32'h5A);
        rsp_ready_i = 1'b1;
        @(negedge clk40MHz_i);
        rsp_ready_i = 1'b0;
        exp_txn += 2;
        chk("bp_txn_cnt", 32'(txn_cnt_o), 32'(exp_txn));

        // Reset in the middle of a slow-ack write
        ack_delay = 5;
        @(negedge clk40MHz_i);
        cmd_valid_i = 1'b1; cmd_wen_i = 1'b1; cmd_adr_i = 16'h0002; cmd_dat_i = 8'h77;
        @(negedge clk40MHz_i);
        cmd_valid_i = 1'b0;
        chk("rb_stb_up", 32'(wb_stb_o), 32'd1);
        repeat (2) @(negedge clk40MHz_i);
        rst_n_i = 1'b0;
        #1;
        chk("rb_stb_async_low", 32'(wb_stb_o), 32'd0);
        chk("rb_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rb_txn_cnt", 32'(txn_cnt_o), 32'd0);
        chk("rb_err_cnt", 32'(err_cnt_o), 32'd0);
        ack_delay = 0;
        cmd_valid_i = 1'b1; cmd_wen_i = 1'b0; cmd_adr_i = 16'h0000; cmd_dat_i = 8'h00;
        repeat (2) @(negedge clk40MHz_i);
        chk("rb_no_rsp_in_reset", 32'(rsp_valid_o), 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk40MHz_i);
        chk("rb_first_edge_accept", 32'(wb_stb_o), 32'd1);
        cmd_valid_i = 1'b0;
        @(negedge clk40MHz_i);
        chk("rb_next_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("rb_next_rsp_dat", 32'(rsp_dat_o), 32'h5A);
        chk("rb_next_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rb_next_txn_cnt", 32'(txn_cnt_o), 32'd1);
        chk("rb_aborted_write", 32'(mem[2]), 32'h00);
        rsp_ready_i = 1'b1;
        @(negedge clk40MHz_i);
        rsp_ready_i = 1'b0;

        // Counter limits: 260 timeouts from a clean reset
        rst_n_i = 1'b0;
        @(negedge clk40MHz_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 260; i++) begin
            do_txn(1'b0, 16'hFFE0, 8'h00, r_dat, r_err, stb_cyc, lat, hold_ok);
            if (i == 254) chk("lim_err_at_255", 32'(err_cnt_o), 32'd255);
        end
        chk("lim_last_err", 32'(r_err), 32'd1);
        chk("lim_last_stb_cycles", 32'(stb_cyc), 32'(TO));
        chk("lim_err_saturate", 32'(err_cnt_o), 32'd255);
        chk("lim_txn_wrap", 32'(txn_cnt_o), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_host_initiator.md
WB_HOST_INITIATOR -- requirements
Module: wb_host_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles wb_stb_o stays high awaiting wb_ack_i (legal range 2..256).
REQ-002 SHALL have port clk40MHz_i  input  1  40 MHz clock; all flops clock on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid_i  input  1  host command valid.
REQ-005 SHALL have port cmd_ready_o  output  1  block can accept a command.
REQ-006 SHALL have port cmd_adr_i  input  16  target bus address.
REQ-007 SHALL have port cmd_wen_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_dat_i  input  8  write data.
REQ-009 SHALL have port rsp_valid_o  output  1  response valid.
REQ-010 SHALL have port rsp_ready_i  input  1  host accepts response.
REQ-011 SHALL have port rsp_dat_o  output  8  read data (0x00 for writes and timeouts).
REQ-012 SHALL have port rsp_err_o  output  1  transaction timed out.
REQ-013 SHALL have ports wb_adr_o (output, 16), wb_wen_o (output, 1), wb_stb_o (output, 1) and wb_dat_o (output, 8), which carry bus address, write enable, strobe and write data.
REQ-014 SHALL have ports wb_dat_i (input, 8), wb_ack_i (input, 1) and wb_val_i (input, 1), which carry slave read data, acknowledge, and slave-selected indication (OR of all slaves' val).
REQ-015 SHALL have ports txn_cnt_o (output, 8) and err_cnt_o (output, 8), which count completed transactions and timeouts.

Function
REQ-016 SHALL implement states IDLE, BUS, RESP; cmd_ready_o = 1 only in IDLE; wb_stb_o = 1 only in BUS; rsp_valid_o = 1 only in RESP.
REQ-017 SHALL, in IDLE, on a rising edge with cmd_valid_i = 1: latch cmd_adr_i/cmd_wen_i/cmd_dat_i into wb_adr_o/wb_wen_o/wb_dat_o, clear the wait counter, and go to BUS.
REQ-018 SHALL hold wb_adr_o, wb_wen_o and wb_dat_o stable throughout BUS, and keep their last values in RESP/IDLE until the next accepted command.
REQ-019 SHALL, in BUS, on an edge with wb_ack_i = 1: set rsp_dat_o = wb_dat_i for reads or 0x00 for writes, clear rsp_err_o, and go to RESP; wb_stb_o is therefore high for exactly one cycle when the slave acks combinationally (one slave write per transaction).
REQ-020 SHALL, in BUS with wb_ack_i = 0, increment the wait counter each edge; on the edge where the counter equals TIMEOUT-1, set rsp_err_o = 1 and rsp_dat_o = 0x00, and go to RESP (wb_stb_o high for exactly TIMEOUT cycles).
REQ-021 SHALL ignore wb_val_i for completion; wb_ack_i alone ends a transaction.
REQ-022 SHALL, in RESP, hold rsp_dat_o/rsp_err_o stable; on an edge with rsp_ready_i = 1, go to IDLE; with rsp_ready_i = 0, remain in RESP indefinitely.
REQ-023 SHALL give a minimum command-accept to rsp_valid_o latency of 2 cycles and a minimum issue interval of 3 cycles; wb_stb_o is always low for at least 2 cycles between transactions.
REQ-024 SHALL ignore cmd_valid_i outside IDLE, with no command buffering.
REQ-025 SHALL increment txn_cnt_o (wrapping 255 -> 0) on every BUS -> RESP transition, including timeouts.
REQ-026 SHALL increment err_cnt_o, saturating at 255, on every timeout.
REQ-027 SHALL take wb_ack_i = 1 seen outside BUS as having no effect.

Reset
REQ-028 SHALL, while rst_n_i = 0, asynchronously force state IDLE, and force to 0: wait counter, wb_adr_o, wb_wen_o, wb_stb_o, wb_dat_o, rsp_dat_o, rsp_err_o, txn_cnt_o and err_cnt_o.
REQ-029 SHALL, when reset is asserted mid-BUS, deassert wb_stb_o immediately (not at the next edge), discard the transaction, and emit no response.
REQ-030 SHALL accept a command at the first rising edge after rst_n_i deasserts.

Verification
REQ-031 SHALL cover: write adr 0x0000, dat 0x5A, slave model with ack = stb & val -> stb high 1 cycle, slave register = 0x5A, rsp_valid 2 cycles after accept, rsp_err 0, rsp_dat 0x00, txn_cnt 1.
REQ-032 SHALL cover: read adr 0x0000 after that write -> rsp_dat 0x5A, rsp_err 0, wb_wen_o 0 throughout BUS.
REQ-033 SHALL cover: TIMEOUT = 8, read to unmapped adr 0xFFE0 (ack held 0) -> stb high exactly 8 cycles, rsp_err 1, rsp_dat 0x00, err_cnt 1, txn_cnt incremented.
REQ-034 SHALL cover: rsp_ready_i held 0 for 10 cycles with cmd_valid_i held 1 -> rsp held stable, cmd_ready_o 0, no new stb until 1 cycle after rsp_ready_i rises.
REQ-035 SHALL cover: rst_n_i pulsed low during BUS with a slave ack delayed 5 cycles -> stb falls asynchronously, no rsp_valid, all counters 0, next command completes normally.
REQ-036 SHALL cover: 260 consecutive timeouts -> err_cnt_o saturates at 255 and txn_cnt_o wraps to 4.
